// File: rtl/int_coprocessor_nested_if.sv
// Core <-> interrupt coprocessor handshake and CSR bus.
interface int_coprocessor_nested_if #(
  parameter int N_CH = 3,
  parameter int ID_W = $clog2(N_CH + 1)
);
  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic            int_ack;
  logic [31:0]     epc_in;
  logic            eoi;
  logic [31:0]     epc_out;
  logic            ie_w_en;
  logic            ie_w_data;
  logic            mask_w_en;
  logic [N_CH-1:0] mask_w_data;
  logic [31:0]     ie;
  logic [31:0]     mask;
  logic [31:0]     pending;
  logic [31:0]     in_service;
  logic [ID_W-1:0] nest_level;

  modport master (
    output int_ack, epc_in, eoi, ie_w_en, ie_w_data, mask_w_en, mask_w_data,
    input  int_req, int_id, epc_out, ie, mask, pending, in_service, nest_level
  );
  modport slave (
    input  int_ack, epc_in, eoi, ie_w_en, ie_w_data, mask_w_en, mask_w_data,
    output int_req, int_id, epc_out, ie, mask, pending, in_service, nest_level
  );
endinterface

// File: rtl/int_coprocessor_nested.sv
// Nested fixed-priority interrupt coprocessor: per-channel sync/pending lanes,
// in-service register and EPC stack. All state updates on the falling clock edge.
module int_coprocessor_nested_lane #(
  parameter bit EDGE        = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic irq,
  input  logic ack_clr,
  output logic pend
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
      pend <= 1'b0;
    end else begin
      sync <= (sync << 1) | SYNC_STAGES'(irq);
      if (en) begin
        hist <= s;
        // a fresh edge beats a same-cycle ack so the new request is not lost
        if (EDGE) begin
          if (s && !hist)   pend <= 1'b1;
          else if (ack_clr) pend <= 1'b0;
        end else begin
          pend <= s;
        end
      end
    end
  end
endmodule

module int_coprocessor_nested #(
  parameter int              N_CH        = 3,
  parameter logic [N_CH-1:0] TRIG_EDGE   = {N_CH{1'b1}},
  parameter int              SYNC_STAGES = 2,
  parameter int              ID_W        = $clog2(N_CH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] irq_in,
  int_coprocessor_nested_if.slave bus
);
  logic [N_CH-1:0] pend, ack_clr, in_svc, mask_r, elig, win_oh, top_oh;
  logic            ie_r, int_req, ack_ok, eoi_ok;
  logic [ID_W-1:0] nest, win_id, isr_top;
  logic [31:0]     stack [N_CH];
  logic [31:0]     epc_top;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    int_coprocessor_nested_lane #(.EDGE(TRIG_EDGE[g]), .SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk(clk), .rst_n(rst_n), .en(en), .irq(irq_in[g]),
      .ack_clr(ack_clr[g]), .pend(pend[g])
    );
    // only channels strictly above the current handler may preempt it
    assign elig[g] = pend[g] & mask_r[g] & ((in_svc == '0) || (ID_W'(g) > isr_top));
  end

  always_comb begin
    isr_top = '0;
    top_oh  = '0;
    win_id  = '0;
    win_oh  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_svc[i]) begin
        isr_top   = ID_W'(i);
        top_oh    = '0;
        top_oh[i] = 1'b1;
      end
      if (elig[i]) begin
        win_id    = ID_W'(i + 1);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    epc_top = '0;
    for (int i = 0; i < N_CH; i++)
      if (nest == ID_W'(i + 1)) epc_top = stack[i];
  end

  assign int_req = ie_r & (win_id != '0);
  assign ack_ok  = en & bus.int_ack & int_req;
  assign eoi_ok  = en & bus.eoi & ~ack_ok & (nest != '0);
  assign ack_clr = {N_CH{ack_ok}} & win_oh;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_svc <= '0;
      mask_r <= '1;
      ie_r   <= 1'b1;
      nest   <= '0;
      for (int i = 0; i < N_CH; i++) stack[i] <= '0;
    end else if (en) begin
      if (bus.mask_w_en) mask_r <= bus.mask_w_data;
      if (ack_ok) begin
        in_svc <= in_svc | win_oh;
        nest   <= nest + ID_W'(1);
        ie_r   <= 1'b0;
        for (int i = 0; i < N_CH; i++)
          if (nest == ID_W'(i)) stack[i] <= bus.epc_in;
      end else if (eoi_ok) begin
        in_svc <= in_svc & ~top_oh;
        nest   <= nest - ID_W'(1);
        ie_r   <= 1'b1;
      end else if (bus.ie_w_en) begin
        ie_r <= bus.ie_w_data;
      end
    end
  end

  assign bus.int_req    = int_req;
  assign bus.int_id     = win_id;
  assign bus.epc_out    = epc_top;
  assign bus.ie         = {31'b0, ie_r};
  assign bus.mask       = 32'(mask_r);
  assign bus.pending    = 32'(pend);
  assign bus.in_service = 32'(in_svc);
  assign bus.nest_level = nest;
endmodule

// File: tb/tb_int_coprocessor_nested.sv
// Directed bench: 3-channel edge instance plus a 4-channel instance with a level channel.
module tb_int_coprocessor_nested;
  logic       clk = 1'b1;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] irq_a = '0;
  logic [3:0] irq_b = '0;
  int         n_cmp = 0;
  int         n_err = 0;

  int_coprocessor_nested_if #(.N_CH(3)) ba ();
  int_coprocessor_nested_if #(.N_CH(4)) bb ();

  int_coprocessor_nested #(.N_CH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .irq_in(irq_a), .bus(ba)
  );
  int_coprocessor_nested #(.N_CH(4), .TRIG_EDGE(4'b0111)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .irq_in(irq_b), .bus(bb)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_a(input logic [31:0] pc);
    ba.epc_in = pc; ba.int_ack = 1'b1; tick(); ba.int_ack = 1'b0;
  endtask

  task automatic eoi_a();
    ba.eoi = 1'b1; tick(); ba.eoi = 1'b0;
  endtask

  task automatic pulse_a(input logic [2:0] v);
    irq_a = v; tick(); irq_a = '0; tick(2);
  endtask

  task automatic wr_ie_a(input logic v);
    ba.ie_w_en = 1'b1; ba.ie_w_data = v; tick(); ba.ie_w_en = 1'b0;
  endtask

  initial begin
    {ba.int_ack, ba.eoi, ba.ie_w_en, ba.ie_w_data, ba.mask_w_en} = '0;
    ba.epc_in = '0; ba.mask_w_data = '0;
    {bb.int_ack, bb.eoi, bb.ie_w_en, bb.ie_w_data, bb.mask_w_en} = '0;
    bb.epc_in = '0; bb.mask_w_data = '0;
    tick(2);
    chk("rst_int_req", 32'(ba.int_req), 0);
    chk("rst_int_id", 32'(ba.int_id), 0);
    chk("rst_epc", ba.epc_out, 0);
    chk("rst_ie", ba.ie, 1);
    chk("rst_mask", ba.mask, 32'h7);
    chk("rst_pending", ba.pending, 0);
    chk("rst_nest", 32'(ba.nest_level), 0);
    rst_n = 1'b1; en = 1'b1;

    // single edge request and entry
    pulse_a(3'b001);
    chk("t1_pending", ba.pending, 1);
    chk("t1_req", 32'(ba.int_req), 1);
    chk("t1_id", 32'(ba.int_id), 1);
    ack_a(32'h100);
    chk("t1_ack_req", 32'(ba.int_req), 0);
    chk("t1_ack_isr", ba.in_service, 1);
    chk("t1_ack_nest", 32'(ba.nest_level), 1);
    chk("t1_ack_epc", ba.epc_out, 32'h100);
    chk("t1_ack_ie", ba.ie, 0);
    chk("t1_ack_pend", ba.pending, 0);

    // nested preemption by ch2
    wr_ie_a(1'b1);
    chk("t2_ie_wr", ba.ie, 1);
    pulse_a(3'b100);
    chk("t2_id", 32'(ba.int_id), 3);
    chk("t2_req", 32'(ba.int_req), 1);
    ack_a(32'h200);
    chk("t2_nest", 32'(ba.nest_level), 2);
    chk("t2_epc", ba.epc_out, 32'h200);
    chk("t2_isr", ba.in_service, 32'h5);
    eoi_a();
    chk("t2_eoi1_isr", ba.in_service, 1);
    chk("t2_eoi1_epc", ba.epc_out, 32'h100);
    chk("t2_eoi1_ie", ba.ie, 1);
    eoi_a();
    chk("t2_eoi2_nest", 32'(ba.nest_level), 0);
    chk("t2_eoi2_epc", ba.epc_out, 0);
    chk("t2_eoi2_ie", ba.ie, 1);

    // lower priority blocked while ch2 in service
    pulse_a(3'b100);
    ack_a(32'h300);
    chk("t3_isr", ba.in_service, 32'h4);
    wr_ie_a(1'b1);
    pulse_a(3'b010);
    chk("t3_pending", ba.pending, 32'h2);
    chk("t3_req_blk", 32'(ba.int_req), 0);
    eoi_a();
    chk("t3_eoi_id", 32'(ba.int_id), 2);
    chk("t3_eoi_req", 32'(ba.int_req), 1);
    ack_a(32'h400);
    chk("t3_ack_isr", ba.in_service, 32'h2);
    eoi_a();
    chk("t3_clean_pend", ba.pending, 0);

    // simultaneous edges and masking
    pulse_a(3'b101);
    chk("t4_id", 32'(ba.int_id), 3);
    chk("t4_pend", ba.pending, 32'h5);
    ba.mask_w_en = 1'b1; ba.mask_w_data = 3'b011; tick(); ba.mask_w_en = 1'b0;
    chk("t4_mask", ba.mask, 32'h3);
    chk("t4_mask_id", 32'(ba.int_id), 1);
    chk("t4_mask_pend", ba.pending, 32'h5);
    ba.mask_w_en = 1'b1; ba.mask_w_data = 3'b111; tick(); ba.mask_w_en = 1'b0;
    chk("t4_unmask_id", 32'(ba.int_id), 3);
    ack_a(32'h10);
    eoi_a();
    chk("t4_next_id", 32'(ba.int_id), 1);
    ack_a(32'h14);
    eoi_a();
    chk("t4_clean_pend", ba.pending, 0);

    // same-cycle ack+eoi, eoi on empty stack, ack without request
    pulse_a(3'b010);
    ack_a(32'h20);
    pulse_a(3'b100);
    wr_ie_a(1'b1);
    chk("t6_id", 32'(ba.int_id), 3);
    ba.epc_in = 32'h30; ba.int_ack = 1'b1; ba.eoi = 1'b1; tick();
    ba.int_ack = 1'b0; ba.eoi = 1'b0;
    chk("t6_both_nest", 32'(ba.nest_level), 2);
    chk("t6_both_isr", ba.in_service, 32'h6);
    chk("t6_both_epc", ba.epc_out, 32'h30);
    chk("t6_both_ie", ba.ie, 0);
    eoi_a();
    chk("t6_pop_epc", ba.epc_out, 32'h20);
    eoi_a();
    eoi_a();
    chk("t6_empty_nest", 32'(ba.nest_level), 0);
    chk("t6_empty_ie", ba.ie, 1);
    ack_a(32'hDEAD);
    chk("t6_noreq_nest", 32'(ba.nest_level), 0);
    chk("t6_noreq_epc", ba.epc_out, 0);
    chk("t6_noreq_isr", ba.in_service, 0);

    // en=0 freezes writes
    en = 1'b0;
    ba.mask_w_en = 1'b1; ba.mask_w_data = 3'b000; ba.ie_w_en = 1'b1; ba.ie_w_data = 1'b0;
    tick();
    ba.mask_w_en = 1'b0; ba.ie_w_en = 1'b0; en = 1'b1;
    chk("t7_en_mask", ba.mask, 32'h7);
    chk("t7_en_ie", ba.ie, 1);

    // level channel on the 4-channel instance
    irq_b = 4'b1000; tick(3);
    chk("t5_pend", bb.pending, 32'h8);
    chk("t5_id", 32'(bb.int_id), 4);
    bb.epc_in = 32'h50; bb.int_ack = 1'b1; tick(); bb.int_ack = 1'b0;
    chk("t5_ack_isr", bb.in_service, 32'h8);
    chk("t5_ack_req", 32'(bb.int_req), 0);
    chk("t5_ack_pend", bb.pending, 32'h8);
    bb.eoi = 1'b1; tick(); bb.eoi = 1'b0;
    chk("t5_eoi_req", 32'(bb.int_req), 1);
    chk("t5_eoi_id", 32'(bb.int_id), 4);
    irq_b = '0; tick(3);
    chk("t5_drop_pend", bb.pending, 0);
    chk("t5_drop_req", 32'(bb.int_req), 0);

    // reset mid-handler
    pulse_a(3'b001);
    ack_a(32'h500);
    chk("t8_pre_nest", 32'(ba.nest_level), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t8_rst_epc", ba.epc_out, 0);
    chk("t8_rst_nest", 32'(ba.nest_level), 0);
    chk("t8_rst_isr", ba.in_service, 0);
    chk("t8_rst_ie", ba.ie, 1);
    chk("t8_rst_mask", ba.mask, 32'h7);
    chk("t8_rst_req", 32'(ba.int_req), 0);
    chk("t8_rst_id", 32'(ba.int_id), 0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/int_coprocessor_nested.md
Name: int_coprocessor_nested

Overview:
- Parametrised interrupt coprocessor for the pipelined core; successor to the fixed 3-line unit.
- Takes N_CH asynchronous interrupt lines, each configurable as edge or level triggered, with a per-channel enable mask.
- Arbitrates by fixed priority (higher index wins) and supports true nesting: an in-service register plus an EPC stack of depth N_CH.
- The core takes an interrupt with an ack pulse and returns with an eoi pulse.

Parameters:
N_CH, 3, number of interrupt channels (1..16)
TRIG_EDGE, all ones (N_CH bits), bit i=1 makes channel i rising-edge triggered; 0 makes it level (active-high)
SYNC_STAGES, 2, synchroniser flops per input (>=1)
ID_W, clog2(N_CH+1), width of channel id

Ports:
clk  in  1  clock; all state updates on falling edge, matching core coprocessor timing
rst_n  in  1  asynchronous active-low reset
en  in  1  global update enable; when 0 all state holds (synchronisers keep sampling)
irq_in  in  N_CH  raw interrupt lines
int_req  out  1  interrupt request to core
int_id  out  ID_W  1+index of winning channel, 0 when none
int_ack  in  1  one-cycle pulse: core enters handler for int_id
epc_in  in  32  return PC pushed on ack
eoi  in  1  one-cycle pulse: handler return
epc_out  out  32  top of EPC stack (0 when stack empty)
ie_w_en  in  1  global enable write strobe
ie_w_data  in  1  global enable write value
mask_w_en  in  1  mask write strobe
mask_w_data  in  N_CH  mask write value
ie  out  32  {31'b0, ie}
mask  out  32  zero-extended channel mask
pending  out  32  zero-extended pending register
in_service  out  32  zero-extended in-service register
nest_level  out  ID_W  current nesting depth

Behaviour:
- Reset (async, immediate): sync flops 0, edge-history 0, pending 0, in_service 0, mask all ones, ie 1, nest_level 0, all stack entries 0. Hence int_req 0, int_id 0, epc_out 0.
- Synchroniser: SYNC_STAGES flops per line; s[i] is the last stage. Edge detection compares s[i] with a history flop.
- Pending, edge channel: set when s[i]=1 and history=0; cleared by an ack selecting i. If a new edge and an ack for the same channel occur in the same cycle, the edge wins and pending stays 1.
- Pending, level channel: pending[i] = s[i], registered each en cycle; ack does not clear it, so the source must deassert.
- Eligible[i] = pending[i] & mask[i] & (i > highest set in_service index, or in_service==0).
- int_id = 1 + highest eligible index, else 0. int_req = ie & (int_id != 0). Both are combinational from registers.
- ack with int_req=1, for channel k=int_id-1: in_service[k] set; stack[nest_level] <= epc_in; nest_level+1; ie <= 0.
- ack with int_req=0: ignored, no state change.
- eoi with nest_level>0: clear highest set in_service bit; nest_level-1; ie <= 1. epc_out then shows the new top, or 0 when the stack is empty.
- eoi with nest_level=0: ignored.
- ack and eoi in the same cycle: ack processed, eoi dropped.
- Nesting depth is bounded by N_CH because each channel can be in service at most once, so the stack cannot overflow.
- ie_w_en takes effect only in cycles without an accepted ack or eoi; ack and eoi override it.
- mask_w_en: mask updates next edge. Pending bits are not cleared by masking.
- en=0: pending, in_service, stack, ie and mask hold. ack, eoi and writes are ignored.
- Reset mid-handler: all state clears immediately and epc_out=0.

Test Plan:
- Reset, edge pulse on irq_in[0] -> after SYNC_STAGES+1 falling edges: pending=1, int_req=1, int_id=1; ack with epc_in=0x100 -> int_req=0, in_service=1, nest_level=1, epc_out=0x100, ie=0.
- While in ch0 handler with ie written 1, pulse irq_in[2] -> int_id=3; ack with epc_in=0x200 -> nest_level=2, epc_out=0x200; eoi -> in_service=1, epc_out=0x100; eoi -> nest_level=0, epc_out=0, ie=1.
- In ch2 handler with ie=1, pulse irq_in[1] -> pending=0b010, int_req=0 (lower priority); after eoi -> int_id=2, int_req=1.
- Edges on channels 0 and 2 simultaneously -> int_id=3; mask_w_data=0b011 -> int_id=1; pending stays 0b101.
- N_CH=4, TRIG_EDGE=0b0111, channel 3 held high -> ack, eoi -> int_req re-asserts with int_id=4; drop the line -> pending[3]=0 after sync latency.
- Same-cycle ack+eoi, eoi on empty stack, ack with int_req=0, and rst_n low mid-handler -> state per Behaviour; all outputs 0 except ie=1 and mask=all ones after reset.
